pc_ras_unit: RTL and testbench
==============================

# pc_ras_unit

Parametrised program-counter unit for the fetch stage of the pipeline. It holds the architectural fetch PC and selects the next PC from trap, resolved-branch redirect, return-address prediction or sequential increment. It also maintains a circular return-address stack (RAS) that the decode stage pushes on calls and pops on returns. All state updates are gated by a global clock enable and a fetch write enable (stall).

## Interface

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; XLEN bits.
- INSTR_BYTES, 4, sequential increment; power of two.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high; overrides all other inputs.
- i_clk_en  in  1  global enable; 0 freezes all state.
- i_wr_en  in  1  fetch advance; 0 = stall. Trap and redirect override it.
- i_trap  in  1  take trap this cycle.
- i_trap_vec  in  XLEN  trap handler address.
- i_redirect  in  1  EX-resolved mispredict or jump.
- i_redirect_pc  in  XLEN  corrected target.
- i_push  in  1  decode saw a call; push i_push_addr.
- i_push_addr  in  XLEN  return address to push.
- i_pop  in  1  decode saw a return; predict and pop.
- o_pc  out  XLEN  current fetch PC (registered).
- o_pc_plus  out  XLEN  o_pc + INSTR_BYTES, modulo 2^XLEN.
- o_ras_top  out  XLEN  top RAS entry; 0 when empty.
- o_ras_empty  out  1  count == 0.
- o_ras_full  out  1  count == RAS_DEPTH.
- o_misaligned  out  1  o_pc[log2(INSTR_BYTES)-1:0] != 0.

## Operation

State:
- PC register.
- RAS array of RAS_DEPTH×XLEN.
- Top pointer (log2(RAS_DEPTH) bits, wraps).
- Count (0..RAS_DEPTH).

Next-state priority, evaluated when i_clk_en=1:
1. i_rst: PC=RESET_VECTOR, pointer=0, count=0, all entries=0. Applies regardless of i_clk_en.
2. i_trap: PC=i_trap_vec; count=0, pointer=0; entries not cleared. i_push/i_pop ignored.
3. i_redirect: PC=i_redirect_pc; RAS untouched. i_push/i_pop ignored, since they come from the flushed instruction.
4. i_wr_en=0: hold PC and RAS.
5. i_wr_en=1, i_pop=1, count>0, i_push=0:
   - PC=o_ras_top.
   - Pointer decrements (wraps), count decrements.
6. i_wr_en=1, i_pop=1, i_push=1, count>0:
   - PC=old top.
   - Top entry overwritten with i_push_addr; pointer and count unchanged.
7. i_wr_en=1, i_pop=1, count==0:
   - PC=PC+INSTR_BYTES (no prediction).
   - If i_push=1, a normal push also occurs.
8. i_wr_en=1, i_push=1, i_pop=0:
   - Pointer increments (wraps) and entry written.
   - Count increments, saturating at RAS_DEPTH. When full, the oldest entry is overwritten (circular).
   - PC=PC+INSTR_BYTES.
9. i_wr_en=1, no push/pop: PC=PC+INSTR_BYTES.

Arithmetic and width rules:
- All PC arithmetic is modulo 2^XLEN: 0xFFFF_FFFC + 4 → 0x0000_0000.
- Targets are loaded verbatim; misaligned targets are flagged via o_misaligned, not corrected.

## Timing

- Every update takes effect on the rising edge; o_pc reflects it in the following cycle. Latency from input to o_pc is 1 cycle.
- o_pc_plus, o_ras_top, o_ras_empty, o_ras_full and o_misaligned are combinational from registered state only; no input→output combinational path.
- Reset values:
  - o_pc=RESET_VECTOR
  - o_pc_plus=RESET_VECTOR+INSTR_BYTES
  - o_ras_top=0
  - o_ras_empty=1
  - o_ras_full=0
  - o_misaligned=RESET_VECTOR low bits != 0
- Reset asserted mid-stream (with pending push/pop/redirect) wins unconditionally in that cycle.
- i_clk_en=0 with i_trap or i_redirect asserted: the event is lost. The sender must hold it until i_clk_en=1.
- Stall with i_push/i_pop asserted: the RAS is not modified. Decode must re-present the request when i_wr_en returns.

## Test plan

- Reset then 3 cycles of i_clk_en=i_wr_en=1 → o_pc 0x0, 0x4, 0x8, 0xC. Toggle i_wr_en=0 for 2 cycles → o_pc holds 0xC.
- Push 0x100, 0x200, then pop → o_pc=0x200 next cycle, o_ras_top=0x100. Pop again → o_pc=0x100, o_ras_empty=1. Pop on empty → o_pc=PC+4.
- RAS_DEPTH=4, push 0x10,0x20,0x30,0x40,0x50 → o_ras_full=1, o_ras_top=0x50. 4 pops yield 0x50,0x40,0x30,0x20, then o_ras_empty=1.
- Same cycle i_trap(0x80), i_redirect(0x300), i_push → o_pc=0x80, o_ras_empty=1. Same cycle redirect(0x300)+pop with count=2 → o_pc=0x300, count stays 2.
- Push and pop together with top=0x40 → o_pc=0x40, o_ras_top=i_push_addr, count unchanged. PC=0xFFFF_FFFC advance → 0x0. Redirect to 0x102 → o_misaligned=1.
- Assert i_rst during a push with count=3 → count=0, o_pc=RESET_VECTOR, o_ras_top=0. i_clk_en=0 with i_redirect → o_pc unchanged.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Fetch PC register with next-PC select (trap > redirect > RAS pop > sequential) and a circular return-address stack.
// One-cycle latency to o_pc; i_wr_en=0 stalls PC and RAS, i_clk_en=0 freezes everything except reset.
module pc_ras_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  input  logic            i_wr_en,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_addr,
  input  logic            i_pop,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus,
  output logic [XLEN-1:0] o_ras_top,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_misaligned
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]   COUNT_MAX  = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic [CW-1:0]   count;
  logic            ras_empty;

  assign ptr_inc   = ptr + PW'(1);
  assign ptr_dec   = ptr - PW'(1);
  assign ras_empty = (count == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc    <= RESET_VECTOR;
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras[i] <= '0;
      end
    end else if (i_clk_en) begin
      if (i_trap) begin
        // Stale entries are left in place; count=0 hides them.
        pc    <= i_trap_vec;
        ptr   <= '0;
        count <= '0;
      end else if (i_redirect) begin
        pc <= i_redirect_pc;
      end else if (i_wr_en) begin
        if (i_pop && !ras_empty) begin
          pc <= ras[ptr];
          if (i_push) begin
            ras[ptr] <= i_push_addr;
          end else begin
            ptr   <= ptr_dec;
            count <= count - CW'(1);
          end
        end else begin
          pc <= o_pc_plus;
          if (i_push) begin
            // When full the pointer wraps onto the oldest entry and replaces it.
            ptr          <= ptr_inc;
            ras[ptr_inc] <= i_push_addr;
            if (count != COUNT_MAX) begin
              count <= count + CW'(1);
            end
          end
        end
      end
    end
  end

  assign o_pc         = pc;
  assign o_pc_plus    = pc + XLEN'(INSTR_BYTES);
  assign o_ras_top    = ras_empty ? '0 : ras[ptr];
  assign o_ras_empty  = ras_empty;
  assign o_ras_full   = (count == COUNT_MAX);
  assign o_misaligned = ((pc & ALIGN_MASK) != '0);

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        i_rst, i_clk_en, i_wr_en, i_trap, i_redirect, i_push, i_pop;
  logic [31:0] i_trap_vec, i_redirect_pc, i_push_addr;
  logic [31:0] o_pc, o_pc_plus, o_ras_top;
  logic        o_ras_empty, o_ras_full, o_misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model: PC plus a bounded stack of visible return addresses (back = top).
  logic [31:0] m_pc;
  logic [31:0] mq[$];

  pc_ras_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_wr_en(i_wr_en),
    .i_trap(i_trap), .i_trap_vec(i_trap_vec), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_push(i_push), .i_push_addr(i_push_addr),
    .i_pop(i_pop), .o_pc(o_pc), .o_pc_plus(o_pc_plus), .o_ras_top(o_ras_top),
    .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full), .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (i_rst) begin
      m_pc = 32'h0;
      mq.delete();
    end else if (i_clk_en) begin
      if (i_trap) begin
        m_pc = i_trap_vec;
        mq.delete();
      end else if (i_redirect) begin
        m_pc = i_redirect_pc;
      end else if (i_wr_en) begin
        if (i_pop && mq.size() > 0) begin
          m_pc = mq[$];
          if (i_push) mq[$] = i_push_addr;
          else void'(mq.pop_back());
        end else begin
          m_pc = m_pc + 32'd4;
          if (i_push) begin
            if (mq.size() == 4) void'(mq.pop_front());
            mq.push_back(i_push_addr);
          end
        end
      end
    end
  endtask

  task automatic idle();
    i_rst = 0; i_clk_en = 1; i_wr_en = 0; i_trap = 0; i_redirect = 0;
    i_push = 0; i_pop = 0; i_trap_vec = 0; i_redirect_pc = 0; i_push_addr = 0;
  endtask

  // Advance one clock with the currently driven inputs, keep the model in step, settle outputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); i_rst = 1; tick();
  endtask

  task automatic do_push(input logic [31:0] a);
    i_wr_en = 1; i_push = 1; i_push_addr = a; tick();
  endtask

  task automatic do_pop();
    i_wr_en = 1; i_pop = 1; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h expected=%h", o_pc, 32'h0); end
    checks++; if (o_pc_plus !== 32'h4) begin errors++; $display("FAIL reset_pc_plus actual=%h expected=%h", o_pc_plus, 32'h4); end
    checks++; if (o_ras_top !== 32'h0) begin errors++; $display("FAIL reset_top actual=%h expected=%h", o_ras_top, 32'h0); end
    checks++; if ({o_ras_empty, o_ras_full, o_misaligned} !== 3'b100) begin errors++; $display("FAIL reset_flags actual=%b expected=%b", {o_ras_empty, o_ras_full, o_misaligned}, 3'b100); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      i_wr_en = 1; tick();
      exp = 32'(i * 4);
      checks++; if (o_pc !== exp) begin errors++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, o_pc, exp); end
    end
    for (int i = 0; i < 2; i++) begin
      i_wr_en = 0; i_push = 1; i_push_addr = 32'hDEAD_0000; tick();
      checks++; if (o_pc !== 32'hC || o_ras_empty !== 1'b1) begin errors++; $display("FAIL stall_hold actual=%h/%b expected=%h/1", o_pc, o_ras_empty, 32'hC); end
    end
  endtask

  task automatic test_ras_basic();
    logic [31:0] pc_before;
    do_push(32'h100);
    do_push(32'h200);
    do_pop();
    checks++; if (o_pc !== 32'h200 || o_ras_top !== 32'h100) begin errors++; $display("FAIL pop1 actual=%h/%h expected=%h/%h", o_pc, o_ras_top, 32'h200, 32'h100); end
    do_pop();
    checks++; if (o_pc !== 32'h100 || o_ras_empty !== 1'b1) begin errors++; $display("FAIL pop2 actual=%h/%b expected=%h/1", o_pc, o_ras_empty, 32'h100); end
    pc_before = o_pc;
    do_pop();
    checks++; if (o_pc !== pc_before + 32'd4) begin errors++; $display("FAIL pop_empty actual=%h expected=%h", o_pc, pc_before + 32'd4); end
  endtask

  task automatic test_ras_wrap();
    logic [31:0] exp;
    do_reset();
    for (int i = 1; i <= 5; i++) do_push(32'(i * 16));
    checks++; if (o_ras_full !== 1'b1 || o_ras_top !== 32'h50) begin errors++; $display("FAIL full_top actual=%b/%h expected=1/%h", o_ras_full, o_ras_top, 32'h50); end
    for (int i = 0; i < 4; i++) begin
      do_pop();
      exp = 32'((5 - i) * 16);
      checks++; if (o_pc !== exp) begin errors++; $display("FAIL wrap_pop%0d actual=%h expected=%h", i, o_pc, exp); end
    end
    checks++; if (o_ras_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty actual=%b expected=1", o_ras_empty); end
  endtask

  task automatic test_priority();
    do_reset();
    do_push(32'h500);
    do_push(32'h600);
    i_trap = 1; i_trap_vec = 32'h80; i_redirect = 1; i_redirect_pc = 32'h300;
    i_wr_en = 1; i_push = 1; i_push_addr = 32'h900; tick();
    checks++; if (o_pc !== 32'h80 || o_ras_empty !== 1'b1) begin errors++; $display("FAIL trap_prio actual=%h/%b expected=%h/1", o_pc, o_ras_empty, 32'h80); end
    do_push(32'hA00);
    do_push(32'hB00);
    i_redirect = 1; i_redirect_pc = 32'h300; i_wr_en = 1; i_pop = 1; tick();
    checks++; if (o_pc !== 32'h300 || o_ras_top !== 32'hB00) begin errors++; $display("FAIL redir_pop actual=%h/%h expected=%h/%h", o_pc, o_ras_top, 32'h300, 32'hB00); end
    do_pop();
    do_pop();
    checks++; if (o_pc !== 32'hA00 || o_ras_empty !== 1'b1) begin errors++; $display("FAIL redir_count actual=%h/%b expected=%h/1", o_pc, o_ras_empty, 32'hA00); end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_push(32'h30);
    do_push(32'h40);
    i_wr_en = 1; i_push = 1; i_push_addr = 32'h77; i_pop = 1; tick();
    checks++; if (o_pc !== 32'h40 || o_ras_top !== 32'h77) begin errors++; $display("FAIL pushpop actual=%h/%h expected=%h/%h", o_pc, o_ras_top, 32'h40, 32'h77); end
    do_pop();
    do_pop();
    checks++; if (o_pc !== 32'h30 || o_ras_empty !== 1'b1) begin errors++; $display("FAIL pushpop_count actual=%h/%b expected=%h/1", o_pc, o_ras_empty, 32'h30); end
  endtask

  task automatic test_pc_edges();
    i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFC; tick();
    checks++; if (o_pc_plus !== 32'h0) begin errors++; $display("FAIL pc_plus_wrap actual=%h expected=%h", o_pc_plus, 32'h0); end
    i_wr_en = 1; tick();
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap actual=%h expected=%h", o_pc, 32'h0); end
    i_redirect = 1; i_redirect_pc = 32'h102; tick();
    checks++; if (o_pc !== 32'h102 || o_misaligned !== 1'b1) begin errors++; $display("FAIL misaligned actual=%h/%b expected=%h/1", o_pc, o_misaligned, 32'h102); end
  endtask

  task automatic test_reset_mid_and_clk_en();
    do_push(32'h1000);
    do_push(32'h2000);
    do_push(32'h3000);
    i_rst = 1; i_wr_en = 1; i_push = 1; i_push_addr = 32'h4000; i_redirect = 1; i_redirect_pc = 32'h44; tick();
    checks++; if (o_pc !== 32'h0 || o_ras_top !== 32'h0 || o_ras_empty !== 1'b1) begin errors++; $display("FAIL reset_mid actual=%h/%h/%b expected=0/0/1", o_pc, o_ras_top, o_ras_empty); end
    do_push(32'h5000);
    i_clk_en = 0; i_redirect = 1; i_redirect_pc = 32'h300; tick();
    checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL clk_en_redirect actual=%h expected=%h", o_pc, 32'h4); end
    i_clk_en = 0; i_wr_en = 1; i_pop = 1; tick();
    checks++; if (o_pc !== 32'h4 || o_ras_top !== 32'h5000) begin errors++; $display("FAIL clk_en_pop actual=%h/%h expected=%h/%h", o_pc, o_ras_top, 32'h4, 32'h5000); end
  endtask

  task automatic test_random();
    logic [31:0] exp_top;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      i_rst         = ($urandom_range(99) < 2);
      i_clk_en      = ($urandom_range(99) < 90);
      i_wr_en       = ($urandom_range(99) < 80);
      i_trap        = ($urandom_range(99) < 4);
      i_redirect    = ($urandom_range(99) < 8);
      i_push        = ($urandom_range(99) < 40);
      i_pop         = ($urandom_range(99) < 40);
      i_trap_vec    = $urandom & 32'hFFFF_FFFC;
      i_redirect_pc = $urandom & (($urandom_range(9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      i_push_addr   = $urandom;
      tick();
      exp_top = (mq.size() > 0) ? mq[$] : 32'h0;
      checks++;
      if (o_pc !== m_pc || o_pc_plus !== m_pc + 32'd4 || o_ras_top !== exp_top ||
          o_ras_empty !== (mq.size() == 0) || o_ras_full !== (mq.size() == 4) ||
          o_misaligned !== (m_pc[1:0] != 2'b00)) begin
        errors++;
        $display("FAIL random_%0d actual pc=%h plus=%h top=%h e=%b f=%b m=%b expected pc=%h top=%h depth=%0d",
                 n, o_pc, o_pc_plus, o_ras_top, o_ras_empty, o_ras_full, o_misaligned, m_pc, exp_top, mq.size());
      end
    end
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_ras_basic();
    test_ras_wrap();
    test_priority();
    test_push_pop();
    test_pc_edges();
    test_reset_mid_and_clk_en();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
